// File: rtl/key_cache_ctrl.sv
// Tag/valid controller for a 4-way fully associative SM4 round-key cache; misses are filled by the key-expansion unit.
// Latency: hit response 2 cycles after accept; miss fill request 2 cycles after accept, response 1 cycle after fill_done_i.
// Backpressure: single outstanding lookup; req_ready_o low until the response is taken via resp_ready_i, fill held until fill_done_i.
module key_cache_ctrl #(
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             req_v_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             req_ready_o,
    output logic             resp_v_o,
    input  logic             resp_ready_i,
    output logic             resp_hit_o,
    output logic [1:0]       resp_way_o,
    output logic             fill_v_o,
    output logic [TAG_W-1:0] fill_tag_o,
    output logic [1:0]       fill_way_o,
    input  logic             fill_done_i,
    input  logic             flush_i,
    output logic [1:0]       lru_access1_o,
    output logic             lru_v1_o,
    output logic [1:0]       lru_access2_o,
    output logic             lru_v2_o,
    input  logic [1:0]       lru_replace_i,
    output logic [CNT_W-1:0] hit_cnt_o,
    output logic [CNT_W-1:0] miss_cnt_o
);

    typedef enum logic [1:0] {IDLE, CMP, FILL, RESP} state_t;

    state_t             state_q, state_d;
    logic [TAG_W-1:0]   tag_q [4];
    logic [3:0]         valid_q;
    logic               flush_pend_q;
    logic [TAG_W-1:0]   lat_tag_q;
    logic [1:0]         way_q;
    logic               hit_q;
    logic [CNT_W-1:0]   hit_cnt_q, miss_cnt_q;

    logic [3:0]         match;
    logic               hit_any;
    logic [1:0]         hit_way;
    logic [1:0]         victim;
    logic               req_acc;
    logic               flush_now;

    // Tag compare against all valid ways and victim choice (lowest invalid way, else recorder's pick).
    always_comb begin
        hit_way = 2'd0;
        victim  = lru_replace_i;
        for (int i = 0; i < 4; i++) begin
            match[i] = valid_q[i] && (tag_q[i] == lat_tag_q);
            if (match[i]) hit_way = 2'(i);
        end
        for (int i = 3; i >= 0; i--) begin
            if (!valid_q[i]) victim = 2'(i);
        end
        hit_any = |match;
    end

    assign flush_now = (state_q == IDLE) && (flush_i || flush_pend_q);
    assign req_acc   = (state_q == IDLE) && req_v_i && !flush_i && !flush_pend_q && !reset_i;

    // Next-state and handshake outputs; reset forces every valid low in the same cycle.
    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        resp_v_o    = 1'b0;
        fill_v_o    = 1'b0;
        lru_v1_o    = 1'b0;
        lru_v2_o    = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = !flush_i && !flush_pend_q;
                if (req_acc) state_d = CMP;
            end
            CMP: begin
                lru_v1_o = hit_any;
                state_d  = hit_any ? RESP : FILL;
            end
            FILL: begin
                fill_v_o = 1'b1;
                if (fill_done_i) begin
                    lru_v2_o = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                resp_v_o = 1'b1;
                if (resp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (reset_i) begin
            state_d     = IDLE;
            req_ready_o = 1'b0;
            resp_v_o    = 1'b0;
            fill_v_o    = 1'b0;
            lru_v1_o    = 1'b0;
            lru_v2_o    = 1'b0;
        end
    end

    assign lru_access1_o = hit_way;
    assign lru_access2_o = way_q;
    assign fill_tag_o    = lat_tag_q;
    assign fill_way_o    = way_q;
    assign resp_hit_o    = hit_q;
    assign resp_way_o    = way_q;
    assign hit_cnt_o     = hit_cnt_q;
    assign miss_cnt_o    = miss_cnt_q;

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Tag storage: written when the fill completes; meaningless while the way is invalid.
    always_ff @(posedge clk_i) begin
        if (!reset_i && state_q == FILL && fill_done_i) tag_q[way_q] <= lat_tag_q;
    end

    // Valid bits, deferred flush, latched request, response fields and saturating counters.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q      <= 4'b0;
            flush_pend_q <= 1'b0;
            lat_tag_q    <= '0;
            way_q        <= 2'd0;
            hit_q        <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            if (flush_i && state_q != IDLE) flush_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (flush_now) begin
                        valid_q      <= 4'b0;
                        flush_pend_q <= 1'b0;
                    end else if (req_acc) begin
                        lat_tag_q <= req_tag_i;
                    end
                end
                CMP: begin
                    if (hit_any) begin
                        way_q <= hit_way;
                        hit_q <= 1'b1;
                        if (hit_cnt_q != '1) hit_cnt_q <= hit_cnt_q + 1'b1;
                    end else begin
                        way_q           <= victim;
                        hit_q           <= 1'b0;
                        valid_q[victim] <= 1'b0;
                        if (miss_cnt_q != '1) miss_cnt_q <= miss_cnt_q + 1'b1;
                    end
                end
                FILL: begin
                    if (fill_done_i) valid_q[way_q] <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_key_cache_ctrl.sv
// Directed bench for key_cache_ctrl with 2-bit counters so saturation is reachable.
// Latency: not applicable (bench).
// Backpressure: response consumer stalls are driven explicitly per lookup.
module tb_key_cache_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_v = 1'b0;
    logic [31:0] req_tag = '0;
    logic        req_ready;
    logic        resp_v;
    logic        resp_ready = 1'b0;
    logic        resp_hit;
    logic [1:0]  resp_way;
    logic        fill_v;
    logic [31:0] fill_tag;
    logic [1:0]  fill_way;
    logic        fill_done = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  lru_access1;
    logic        lru_v1;
    logic [1:0]  lru_access2;
    logic        lru_v2;
    logic [1:0]  lru_replace = 2'd0;
    logic [1:0]  hit_cnt;
    logic [1:0]  miss_cnt;

    int checks = 0;
    int errors = 0;

    key_cache_ctrl #(.TAG_W(32), .CNT_W(2)) dut (
        .clk_i(clk), .reset_i(reset),
        .req_v_i(req_v), .req_tag_i(req_tag), .req_ready_o(req_ready),
        .resp_v_o(resp_v), .resp_ready_i(resp_ready), .resp_hit_o(resp_hit), .resp_way_o(resp_way),
        .fill_v_o(fill_v), .fill_tag_o(fill_tag), .fill_way_o(fill_way), .fill_done_i(fill_done),
        .flush_i(flush),
        .lru_access1_o(lru_access1), .lru_v1_o(lru_v1),
        .lru_access2_o(lru_access2), .lru_v2_o(lru_v2), .lru_replace_i(lru_replace),
        .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One complete lookup: accept, compare, optional fill (with optional flush during FILL),
    // response held for 'hold' cycles before being taken.
    task automatic lookup(input logic [31:0] t, input logic eh, input logic [1:0] ew,
                          input int hold, input logic fl);
        req_v = 1'b1; req_tag = t;
        #1 chk("req_ready", 32'(req_ready), 32'd1);
        step();
        req_v = 1'b0;
        #1 chk("cmp_lru_v1", 32'(lru_v1), 32'(eh));
        if (eh) chk("cmp_lru_acc1", 32'(lru_access1), 32'(ew));
        step();
        if (!eh) begin
            #1 chk("fill_v", 32'(fill_v), 32'd1);
            chk("fill_way", 32'(fill_way), 32'(ew));
            chk("fill_tag", fill_tag, t);
            if (fl) begin
                flush = 1'b1;
                step();
                flush = 1'b0;
                #1 chk("fill_v_after_flush", 32'(fill_v), 32'd1);
            end
            fill_done = 1'b1;
            #1 chk("fill_lru_v2", 32'(lru_v2), 32'd1);
            chk("fill_lru_acc2", 32'(lru_access2), 32'(ew));
            chk("fill_lru_v1", 32'(lru_v1), 32'd0);
            step();
            fill_done = 1'b0;
        end
        for (int i = 0; i <= hold; i++) begin
            #1 chk("resp_v", 32'(resp_v), 32'd1);
            chk("resp_hit", 32'(resp_hit), 32'(eh));
            chk("resp_way", 32'(resp_way), 32'(ew));
            chk("resp_req_ready", 32'(req_ready), 32'd0);
            if (i < hold) step();
        end
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        #1 chk("idle_resp_v", 32'(resp_v), 32'd0);
        chk("idle_req_ready", 32'(req_ready), 32'(!fl));
    endtask

    initial begin
        // Reset state
        step(); step();
        #1 chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_v", 32'(resp_v), 32'd0);
        chk("rst_fill_v", 32'(fill_v), 32'd0);
        chk("rst_lru_v1", 32'(lru_v1), 32'd0);
        chk("rst_lru_v2", 32'(lru_v2), 32'd0);
        chk("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        reset = 1'b0;
        step();

        // 1: miss into way 0, then hit
        lookup(32'hA, 1'b0, 2'd0, 0, 1'b0);
        chk("miss_cnt_1", 32'(miss_cnt), 32'd1);
        lookup(32'hA, 1'b1, 2'd0, 0, 1'b0);
        chk("hit_cnt_1", 32'(hit_cnt), 32'd1);

        // 5: flush beats a same-cycle request; request accepted next cycle and misses
        req_v = 1'b1; req_tag = 32'hA; flush = 1'b1;
        #1 chk("flush_req_ready", 32'(req_ready), 32'd0);
        step();
        flush = 1'b0; req_v = 1'b0;
        #1 chk("flush_no_accept_lru_v1", 32'(lru_v1), 32'd0);
        lookup(32'hA, 1'b0, 2'd0, 0, 1'b0);
        chk("miss_cnt_2", 32'(miss_cnt), 32'd2);

        // 2: empty the cache, fill 1..4, touch 1, evict 2 via recorder choice
        flush = 1'b1; step(); flush = 1'b0;
        lookup(32'h1, 1'b0, 2'd0, 0, 1'b0);
        lookup(32'h2, 1'b0, 2'd1, 0, 1'b0);
        lookup(32'h3, 1'b0, 2'd2, 0, 1'b0);
        lookup(32'h4, 1'b0, 2'd3, 0, 1'b0);
        chk("miss_cnt_sat", 32'(miss_cnt), 32'd3);
        lookup(32'h1, 1'b1, 2'd0, 0, 1'b0);
        chk("hit_cnt_2", 32'(hit_cnt), 32'd2);
        lru_replace = 2'd1;
        lookup(32'h5, 1'b0, 2'd1, 0, 1'b0);
        lru_replace = 2'd2;
        lookup(32'h2, 1'b0, 2'd2, 0, 1'b0);
        lookup(32'h4, 1'b1, 2'd3, 0, 1'b0);
        lookup(32'h2, 1'b1, 2'd2, 0, 1'b0);
        // 6: four-plus hits saturate the 2-bit counter
        chk("hit_cnt_sat", 32'(hit_cnt), 32'd3);

        // 3: consumer stalls five cycles on a hit of tag 5 in way 1
        lookup(32'h5, 1'b1, 2'd1, 5, 1'b0);
        chk("hit_cnt_still_sat", 32'(hit_cnt), 32'd3);

        // 4: flush during FILL; response completes, one blocked IDLE cycle, then everything misses
        lru_replace = 2'd0;
        lookup(32'h7, 1'b0, 2'd0, 0, 1'b1);
        step();
        #1 chk("post_flush_req_ready", 32'(req_ready), 32'd1);
        lookup(32'h7, 1'b0, 2'd0, 0, 1'b0);
        lookup(32'h4, 1'b0, 2'd1, 0, 1'b0);
        chk("flush_keeps_hit_cnt", 32'(hit_cnt), 32'd3);

        // 6: reset in the middle of a fill (victim is lowest invalid way 2)
        req_v = 1'b1; req_tag = 32'h9;
        step();
        req_v = 1'b0;
        step();
        #1 chk("pre_rst_fill_v", 32'(fill_v), 32'd1);
        chk("pre_rst_fill_way", 32'(fill_way), 32'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1 chk("post_rst_fill_v", 32'(fill_v), 32'd0);
        chk("post_rst_resp_v", 32'(resp_v), 32'd0);
        chk("post_rst_hit_cnt", 32'(hit_cnt), 32'd0);
        chk("post_rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("post_rst_req_ready", 32'(req_ready), 32'd1);
        lookup(32'h7, 1'b0, 2'd0, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
